// File: rtl/abro_n_fsm_if.sv
// Event/restart inputs and status outputs of the ABRO-N completion detector.
// The slave modport is the detector's side; the master modport is the environment's side.
interface abro_n_fsm_if #(
    parameter int N_IN  = 2,
    parameter int CNT_W = 8
);
    logic [N_IN-1:0]  ev;
    logic             r;
    logic             o;
    logic [N_IN-1:0]  seen;
    logic [1:0]       state;
    logic [CNT_W-1:0] fire_cnt;
    logic             timeout;

    modport slave (
        input  ev, r,
        output o, seen, state, fire_cnt, timeout
    );

    modport master (
        output ev, r,
        input  o, seen, state, fire_cnt, timeout
    );
endinterface

// File: rtl/abro_n_fsm.sv
// ABRO-N: pulses o once every N_IN events have been seen in any order, then waits for restart r.
// Define ABRO_TIMEOUT_EN to build the partial-arrival timeout that drops a stale seen mask.
module abro_n_fsm #(
    parameter int N_IN        = 2,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    abro_n_fsm_if.slave   bus
);
    typedef enum logic [1:0] {
        S_WAIT = 2'b00,
        S_EMIT = 2'b01,
        S_DONE = 2'b10,
        S_BAD  = 2'b11
    } state_t;

    localparam logic [N_IN-1:0] ALL_ONES = '1;

    // Out-of-range parameters elaborate into this marker block so they are easy to spot.
    if (N_IN < 2 || N_IN > 16 || CNT_W < 1 || CNT_W > 16 || TIMEOUT_CYC < 1) begin : g_illegal_params
    end

    state_t           r_state, w_state_nxt;
    logic             r_o, w_o_nxt;
    logic [N_IN-1:0]  r_seen, w_seen_nxt, w_merged;
    logic [CNT_W-1:0] r_fire_cnt, w_fire_cnt_nxt;
    logic             w_wait_hold;
    logic             w_to_fire;

    always_comb begin
        w_state_nxt    = r_state;
        w_o_nxt        = 1'b0;
        w_seen_nxt     = r_seen;
        w_fire_cnt_nxt = r_fire_cnt;
        w_wait_hold    = 1'b0;
        w_merged       = r_seen | bus.ev;
        case (r_state)
            S_WAIT: begin
                if (bus.r) begin
                    w_seen_nxt = '0;
                end else if (w_merged == ALL_ONES) begin
                    w_state_nxt    = S_EMIT;
                    w_o_nxt        = 1'b1;
                    w_seen_nxt     = ALL_ONES;
                    w_fire_cnt_nxt = r_fire_cnt + CNT_W'(1);
                end else begin
                    w_seen_nxt  = w_merged;
                    w_wait_hold = 1'b1;
                end
            end
            S_EMIT: begin
                // A restart here abandons DONE, but the count already taken stands.
                if (bus.r) begin
                    w_state_nxt = S_WAIT;
                    w_seen_nxt  = '0;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.r) begin
                    w_state_nxt = S_WAIT;
                    w_seen_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = S_WAIT;
                w_seen_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_WAIT;
            r_o        <= 1'b0;
            r_seen     <= '0;
            r_fire_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_o        <= w_o_nxt;
            r_seen     <= w_to_fire ? '0 : w_seen_nxt;
            r_fire_cnt <= w_fire_cnt_nxt;
        end
    end

`ifdef ABRO_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] r_to_cnt, w_to_inc;
    logic            r_timeout;
    logic            w_to_run;

    // The counter ages only a partially filled mask; r and completion never set w_wait_hold.
    assign w_to_run  = w_wait_hold && (r_seen != '0);
    assign w_to_inc  = r_to_cnt + TO_W'(1);
    assign w_to_fire = w_to_run && (w_to_inc == TO_W'(TIMEOUT_CYC));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_to_cnt  <= (w_to_run && !w_to_fire) ? w_to_inc : '0;
            r_timeout <= w_to_fire;
        end
    end

    assign bus.timeout = r_timeout;
`else
    assign w_to_fire   = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign bus.o        = r_o;
    assign bus.seen     = r_seen;
    assign bus.state    = r_state;
    assign bus.fire_cnt = r_fire_cnt;
endmodule

// File: tb/tb_abro_n_fsm.sv
// Bench for abro_n_fsm (N_IN=4, CNT_W=2, TIMEOUT_CYC=3): reference model compared every cycle plus directed literal checks.
module tb_abro_n_fsm;
  localparam int N_IN        = 4;
  localparam int CNT_W       = 2;
  localparam int TIMEOUT_CYC = 3;

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  abro_n_fsm_if #(.N_IN(N_IN), .CNT_W(CNT_W)) bus ();

  abro_n_fsm #(
    .N_IN(N_IN),
    .CNT_W(CNT_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase is kept as "pulse now" / "completed, awaiting r" flags; seen as a mask;
  // count as a plain integer reduced modulo 2^CNT_W when compared.
  logic [N_IN-1:0] m_seen = '0;
  bit m_pulse = 0;
  bit m_done  = 0;
  bit m_to    = 0;
  int m_cnt   = 0;
  int m_age   = 0;
  logic [N_IN-1:0] all_ones;
  assign all_ones = '1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_seen = '0; m_pulse = 0; m_done = 0; m_to = 0; m_cnt = 0; m_age = 0;
    end else begin
      m_to = 0;
      if (m_pulse) begin
        m_pulse = 0;
        if (bus.r) m_seen = '0;
        else       m_done = 1;
      end else if (m_done) begin
        if (bus.r) begin m_done = 0; m_seen = '0; end
      end else if (bus.r) begin
        m_seen = '0; m_age = 0;
      end else if ((m_seen | bus.ev) == all_ones) begin
        m_seen = all_ones; m_pulse = 1; m_cnt = (m_cnt + 1) % (1 << CNT_W); m_age = 0;
      end else begin
`ifdef ABRO_TIMEOUT_EN
        if (m_seen != '0) begin
          m_age++;
          if (m_age == TIMEOUT_CYC) begin m_to = 1; m_age = 0; end
        end else begin
          m_age = 0;
        end
`endif
        m_seen = m_to ? '0 : (m_seen | bus.ev);
      end
    end
  end

  // ---------------- scoreboard: compare every cycle ----------------
  always @(negedge clk) begin
    check("cyc_o", 32'(bus.o), 32'(m_pulse));
    check("cyc_seen", 32'(bus.seen), 32'(m_seen));
    check("cyc_state", 32'(bus.state), m_pulse ? 32'd1 : (m_done ? 32'd2 : 32'd0));
    check("cyc_fire_cnt", 32'(bus.fire_cnt), 32'(m_cnt));
    check("cyc_timeout", 32'(bus.timeout), 32'(m_to));
  end

  // ---------------- driver ----------------
  task automatic step(input logic [N_IN-1:0] e, input logic rr);
    bus.ev = e;
    bus.r  = rr;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic o_e, input logic [N_IN-1:0] s_e,
                            input logic [1:0] st_e, input logic [CNT_W-1:0] c_e);
    check({tag, "_o"}, 32'(bus.o), 32'(o_e));
    check({tag, "_seen"}, 32'(bus.seen), 32'(s_e));
    check({tag, "_state"}, 32'(bus.state), 32'(st_e));
    check({tag, "_cnt"}, 32'(bus.fire_cnt), 32'(c_e));
  endtask

  int wrap_exp[5] = '{1, 2, 3, 0, 1};

  initial begin
    bus.ev = '0;
    bus.r  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    expect_out("reset", 1'b0, 4'b0000, 2'b00, 2'd0);
    check("reset_timeout", 32'(bus.timeout), 32'd0);
    reset_n = 1'b1;

    // partial arrivals, completion one cycle after the last event, DONE ignores ev
    step(4'b0011, 1'b0); expect_out("part1", 1'b0, 4'b0011, 2'b00, 2'd0);
    step(4'b1100, 1'b0); expect_out("part2", 1'b1, 4'b1111, 2'b01, 2'd1);
    step(4'b0000, 1'b0); expect_out("part3", 1'b0, 4'b1111, 2'b10, 2'd1);
    step(4'b1111, 1'b0); expect_out("done_ign", 1'b0, 4'b1111, 2'b10, 2'd1);
    step(4'b0000, 1'b1); expect_out("done_r", 1'b0, 4'b0000, 2'b00, 2'd1);

    // all events at one edge
    step(4'b1111, 1'b0); expect_out("all1", 1'b1, 4'b1111, 2'b01, 2'd2);
    step(4'b0101, 1'b0); expect_out("all2", 1'b0, 4'b1111, 2'b10, 2'd2);
    step(4'b1010, 1'b0); expect_out("all3", 1'b0, 4'b1111, 2'b10, 2'd2);
    step(4'b0000, 1'b1);

    // r beats completion; repeated events; r in EMIT with events present
    step(4'b1111, 1'b1); expect_out("r_prio", 1'b0, 4'b0000, 2'b00, 2'd2);
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0); expect_out("repeat", 1'b0, 4'b0001, 2'b00, 2'd2);
    step(4'b1110, 1'b0); expect_out("cmp3", 1'b1, 4'b1111, 2'b01, 2'd3);
    step(4'b1111, 1'b1); expect_out("emit_r", 1'b0, 4'b0000, 2'b00, 2'd3);
    step(4'b0001, 1'b0); expect_out("recap", 1'b0, 4'b0001, 2'b00, 2'd3);

    // asynchronous reset while in EMIT
    step(4'b1110, 1'b0); expect_out("pre_rst", 1'b1, 4'b1111, 2'b01, 2'd0);
    #2 reset_n = 1'b0;
    #1 expect_out("async_rst", 1'b0, 4'b0000, 2'b00, 2'd0);
    bus.ev = '0;
    @(negedge clk); #1;
    reset_n = 1'b1;
    step(4'b0000, 1'b0); expect_out("post_rst1", 1'b0, 4'b0000, 2'b00, 2'd0);
    step(4'b0000, 1'b0); expect_out("post_rst2", 1'b0, 4'b0000, 2'b00, 2'd0);

    // counter wrap over five completions
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 1'b0);
      check("wrap_cnt", 32'(bus.fire_cnt), 32'(wrap_exp[k]));
      check("wrap_o", 32'(bus.o), 32'd1);
      step(4'b0000, 1'b1);
      check("wrap_state", 32'(bus.state), 32'd0);
    end

    // stale partial mask: dropped by the timeout build, held otherwise
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
`ifdef ABRO_TIMEOUT_EN
    check("to_pulse", 32'(bus.timeout), 32'd1);
    check("to_seen", 32'(bus.seen), 32'd0);
`else
    check("to_pulse", 32'(bus.timeout), 32'd0);
    check("to_seen", 32'(bus.seen), 32'b0001);
`endif
    check("to_state", 32'(bus.state), 32'd0);
    step(4'b0000, 1'b0);
    check("to_once", 32'(bus.timeout), 32'd0);
    step(4'b0000, 1'b1);
    check("to_clear", 32'(bus.seen), 32'd0);

    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: run did not finish, limit 200000 reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/abro_n_fsm.md
ABRO_N_FSM -- requirements
Module: abro_n_fsm

Interface
REQ-001 Parameter N_IN, default 2: number of event inputs; legal range 2..16.
REQ-002 Parameter CNT_W, default 8: width of the completion counter; legal range 1..16.
REQ-003 Parameter TIMEOUT_CYC, default 16: partial-arrival timeout in cycles (used only with REQ-028); legal range >=1.
REQ-004 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ev  in  N_IN  event inputs, level-sampled each rising edge.
- r  in  1  restart request, level-sampled.
- o  out  1  completion pulse.
- seen  out  N_IN  latched arrival mask.
- state  out  2  current FSM state encoding.
- fire_cnt  out  CNT_W  completion count.
- timeout  out  1  timeout pulse.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-006 States SHALL be WAIT=2'b00, EMIT=2'b01, DONE=2'b10; 2'b11 is unused and SHALL transition to WAIT on the next edge with seen cleared.
REQ-007 All outputs SHALL be registered.
REQ-008 In WAIT, each edge: seen <= seen | ev.
REQ-009 In WAIT, when (seen | ev) == all ones at an edge: state <= EMIT, o <= 1, seen <= all ones, fire_cnt <= fire_cnt + 1.
REQ-010 Completion latency SHALL be one cycle: o is high in the cycle after the edge that samples the last missing event.
REQ-011 All N_IN events arriving at the same edge SHALL complete the cycle at that edge.
REQ-012 Events SHALL arrive in any order; repeated assertion of an already-seen event has no effect.
REQ-013 From EMIT, the next edge SHALL go to DONE with o <= 0, so o is exactly one cycle wide.
REQ-014 In DONE, ev SHALL be ignored; seen holds all ones.
REQ-015 In DONE, r sampled high SHALL go to WAIT and clear seen.
REQ-016 r sampled high in WAIT SHALL clear seen and stay in WAIT.
REQ-017 r takes priority over completion at the same edge: no o, no increment.
REQ-018 r sampled high in EMIT SHALL go to WAIT, clear seen, and drive o <= 0; the count already taken stands.
REQ-019 Events present on the edge that leaves DONE or EMIT via r SHALL NOT be captured; capture restarts on the following edge.
REQ-020 fire_cnt SHALL wrap from 2^CNT_W-1 to 0 without a flag.
REQ-021 timeout SHALL be 0 except as in REQ-028.

Reset
REQ-022 While reset_n is low, asynchronously: state=WAIT, o=0, seen=0, fire_cnt=0, timeout=0, and the internal timeout counter is 0.
REQ-023 Reset asserted mid-operation (any state) SHALL abort immediately; no o pulse follows reset release.
REQ-024 After reset_n rises, capture SHALL begin at the first rising edge.

Configuration
REQ-025 Macro ABRO_TIMEOUT_EN SHALL select the timeout feature.
REQ-026 Without ABRO_TIMEOUT_EN: no timeout counter is built, timeout is tied 0, and TIMEOUT_CYC is ignored.
REQ-027 With ABRO_TIMEOUT_EN, the counter SHALL increment each edge in WAIT while seen != 0 and no completion occurs.
REQ-028 With ABRO_TIMEOUT_EN, on the edge where the counter reaches TIMEOUT_CYC:
- seen is cleared;
- timeout <= 1 for exactly one cycle;
- the counter is cleared.
REQ-029 With ABRO_TIMEOUT_EN, the counter SHALL clear on r, on completion, on leaving WAIT, and whenever seen == 0.
REQ-030 With ABRO_TIMEOUT_EN, completion takes priority over timeout at the same edge; r takes priority over both.

Verification
REQ-031 N_IN=2: ev=01, then ev=10 next cycle -> o=1 for one cycle two edges after the first event, state 00->00->01->10, fire_cnt=1.
REQ-032 N_IN=4: ev=1111 in a single cycle -> o pulses next cycle, seen=1111; further ev activity in DONE leaves o=0 and fire_cnt=1.
REQ-033 N_IN=2: ev=11 and r=1 at the same edge -> o stays 0, seen=00, fire_cnt=0; then r=1 in DONE after a later completion -> state=00, seen=00.
REQ-034 CNT_W=2: 5 completions each followed by r -> fire_cnt sequence 1,2,3,0,1.
REQ-035 reset_n driven low mid-cycle during EMIT -> o, seen, and state go to 0 immediately without waiting for clk; no pulse after release.
REQ-036 With ABRO_TIMEOUT_EN, TIMEOUT_CYC=3: ev=01 once, then ev=00 -> timeout pulses once, seen=00, state stays 00; rebuilt without the macro -> timeout stays 0 and seen=01 holds.
